bundle_decoder: RTL

BUNDLE_DECODER -- requirements
Module: bundle_decoder

---
 rtl/bundle_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bundle_decoder.sv
// Majority-style decoder for a noisy redundant wire bundle: counts ones serially,
// classifies the count against two thresholds and keeps saturating transfer statistics.

module bundle_decoder_param_check #(
  parameter int N         = 10,
  parameter int THRESH_HI = 7,
  parameter int THRESH_LO = 3
) ();
  if ((THRESH_LO < 32'sd0) || (THRESH_LO >= THRESH_HI) || (THRESH_HI > N) || (N < 32'sd2)) begin : g_bad_params
    $error("bundle_decoder: illegal parameters (need 0 <= THRESH_LO < THRESH_HI <= N, N >= 2)");
  end
endmodule

module bundle_decoder #(
  parameter int N         = 10,
  parameter int THRESH_HI = 7,
  parameter int THRESH_LO = 3,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             bundle_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     z_o,
  output logic                     ambig_o,
  output logic [$clog2(N+1)-1:0]   count_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     clear_stats_i,
  output logic [CNT_W-1:0]         n_decoded_o,
  output logic [CNT_W-1:0]         n_ambig_o
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0]    LAST_IDX = CW'(N-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  bundle_decoder_param_check #(.N(N), .THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO)) u_param_check ();

  state_t           state_r, state_nxt_s;
  logic [N-1:0]     shift_r;
  logic [CW-1:0]    ones_r, idx_r, ones_nxt_s;
  logic             accept_s, last_s, xfer_s;
  logic             ready_r, valid_r, z_r, ambig_r;
  logic [CW-1:0]    count_r;
  logic [CNT_W-1:0] n_dec_r, n_amb_r;

  // Returns {z, ambig}; a tie between the thresholds resolves to 0.
  function automatic logic [1:0] decide(input logic [CW-1:0] c);
    if (int'(c) >= THRESH_HI) begin
      decide = 2'b10;
    end else if (int'(c) <= THRESH_LO) begin
      decide = 2'b00;
    end else if ((int'(c) + int'(c)) > N) begin
      decide = 2'b11;
    end else begin
      decide = 2'b01;
    end
  endfunction

  // Next-state and handshake event decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    xfer_s      = 1'b0;
    ones_nxt_s  = ones_r + CW'(shift_r[0]);
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == LAST_IDX) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE: begin
        if (ready_i) begin
          xfer_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture and serial LSB-first ones count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= '0;
      ones_r  <= '0;
      idx_r   <= '0;
    end else if (accept_s) begin
      shift_r <= bundle_i;
      ones_r  <= '0;
      idx_r   <= '0;
    end else if (state_r == SCAN) begin
      shift_r <= shift_r >> 1;
      ones_r  <= ones_nxt_s;
      idx_r   <= idx_r + CW'(1'b1);
    end else begin
      shift_r <= shift_r;
      ones_r  <= ones_r;
      idx_r   <= idx_r;
    end
  end

  // Registered handshake and result outputs; results are zero outside DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      z_r     <= 1'b0;
      ambig_r <= 1'b0;
      count_r <= '0;
    end else begin
      ready_r <= (state_nxt_s == IDLE);
      valid_r <= (state_nxt_s == DONE);
      if (last_s) begin
        {z_r, ambig_r} <= decide(ones_nxt_s);
        count_r        <= ones_nxt_s;
      end else if (xfer_s) begin
        z_r     <= 1'b0;
        ambig_r <= 1'b0;
        count_r <= '0;
      end else begin
        z_r     <= z_r;
        ambig_r <= ambig_r;
        count_r <= count_r;
      end
    end
  end

  // Saturating transfer statistics; a clear outranks a coincident transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_dec_r <= '0;
      n_amb_r <= '0;
    end else if (clear_stats_i) begin
      n_dec_r <= '0;
      n_amb_r <= '0;
    end else if (xfer_s) begin
      if (n_dec_r != CNT_MAX) begin
        n_dec_r <= n_dec_r + CNT_W'(1'b1);
      end else begin
        n_dec_r <= n_dec_r;
      end
      if (ambig_r && (n_amb_r != CNT_MAX)) begin
        n_amb_r <= n_amb_r + CNT_W'(1'b1);
      end else begin
        n_amb_r <= n_amb_r;
      end
    end else begin
      n_dec_r <= n_dec_r;
      n_amb_r <= n_amb_r;
    end
  end

  assign ready_o     = ready_r;
  assign valid_o     = valid_r;
  assign z_o         = z_r;
  assign ambig_o     = ambig_r;
  assign count_o     = count_r;
  assign n_decoded_o = n_dec_r;
  assign n_ambig_o   = n_amb_r;

endmodule
